// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber NTT datapath.
//   Q          : Kyber modulus (3329)
//   BARRETT_K  : floor(2^24 / Q), Barrett reciprocal
//   BARRETT_S  : Barrett shift (24)
//   COEFF_W    : coefficient width (12)
//   PROD_W     : full product width (24)
//   QUOT_W     : width of the Barrett quotient estimate m (13)
// -----------------------------------------------------------------------------
package kyber_pkg;

    localparam int Q         = 3329;
    localparam int BARRETT_K = 5039;
    localparam int BARRETT_S = 24;
    localparam int COEFF_W   = 12;
    localparam int PROD_W    = 24;
    // Largest m is (4095^2 * 5039) >> 24 = 5036, which fits in 13 bits.
    localparam int QUOT_W    = 13;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [PROD_W-1:0]  prod_t;
    typedef logic [QUOT_W-1:0]  quot_t;

    // Modulus multiples at product width, for the final correction compares.
    localparam prod_t Q_PROD  = prod_t'(Q);
    localparam prod_t Q2_PROD = prod_t'(2 * Q);

endpackage

// File: rtl/mod_mul_if.sv
// -----------------------------------------------------------------------------
// mod_mul_if
// Operand/result bundle of the modular multiplier.
//   valid_in  : A/B carry a valid operand pair this cycle
//   A, B      : 12-bit operands (0..4095)
//   valid_out : OUT carries a valid result this cycle
//   OUT       : reduced product (0..3328), holds its value between results
// Handshake: valid-only, no back-pressure. A pair is accepted on every rising
// edge where valid_in=1; its result appears with valid_out=1 a fixed number of
// edges later. The consumer must take every valid result on the cycle it shows.
// Modports: master drives operands, slave (the multiplier) drives results.
// -----------------------------------------------------------------------------
interface mod_mul_if;
    import kyber_pkg::*;

    logic   valid_in;
    coeff_t A;
    coeff_t B;
    logic   valid_out;
    coeff_t OUT;

    modport master (output valid_in, output A, output B,
                    input  valid_out, input OUT);
    modport slave  (input  valid_in, input A, input B,
                    output valid_out, output OUT);
endinterface

// File: rtl/mod_mul_barrett_reduce.sv
// -----------------------------------------------------------------------------
// mod_mul_barrett_reduce
// Three-stage Barrett reduction of a 24-bit product modulo 3329.
//   clk       : rising-edge clock
//   r         : asynchronous active-low reset
//   c_in      : product to reduce (registered product from the multiplier)
//   valid_in  : c_in is valid
//   res       : c_in mod Q, loaded only when the last stage holds valid data
//   valid_out : res was just loaded with a valid result
// Stage A: m = (c * K) >> 24          (quotient estimate)
// Stage B: q_mul_m = Q * m
// Stage C: x = c - q_mul_m, fold x from [0,3Q) down to [0,Q)
// -----------------------------------------------------------------------------
module mod_mul_barrett_reduce
    import kyber_pkg::*;
(
    input  logic   clk,
    input  logic   r,
    input  prod_t  c_in,
    input  logic   valid_in,
    output coeff_t res,
    output logic   valid_out
);

    localparam logic [36:0] K_WIDE = 37'(BARRETT_K);

    quot_t m_reg;
    prod_t c_stage2;
    prod_t q_mul_m_reg;
    prod_t c_stage3;
    logic  v2;
    logic  v3;
    prod_t x;
    prod_t x_red;

    // The estimate m undershoots the true quotient by at most 2, so x lies in
    // [0, 3Q) and at most two subtractions of Q are ever needed.
    always_comb begin
        x     = c_stage3 - q_mul_m_reg;
        x_red = x;
        if (x >= Q2_PROD) begin
            x_red = x - Q2_PROD;
        end else if (x >= Q_PROD) begin
            x_red = x - Q_PROD;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            m_reg       <= '0;
            c_stage2    <= '0;
            v2          <= 1'b0;
            q_mul_m_reg <= '0;
            c_stage3    <= '0;
            v3          <= 1'b0;
            res         <= '0;
            valid_out   <= 1'b0;
        end else begin
            // Data moves every cycle; only the valid bit says whether it matters.
            m_reg       <= quot_t'((37'(c_in) * K_WIDE) >> BARRETT_S);
            c_stage2    <= c_in;
            v2          <= valid_in;
            q_mul_m_reg <= prod_t'(m_reg) * Q_PROD;
            c_stage3    <= c_stage2;
            v3          <= v2;
            valid_out   <= v3;
            if (v3) begin
                res <= coeff_t'(x_red);
            end
        end
    end

endmodule

// File: rtl/mod_mul.sv
// -----------------------------------------------------------------------------
// mod_mul
// Fully pipelined modular multiplier, OUT = (A*B) mod 3329, one pair per cycle.
//   clk : rising-edge clock
//   r   : asynchronous active-low reset, clears every pipeline register
//   bus : mod_mul_if.slave (valid_in, A, B in; valid_out, OUT out)
// Stage 1 forms the 24-bit product here; stages 2-4 are the Barrett reducer.
// Latency is 4 edges from sampling valid_in to valid_out.
// Build option MOD_MUL_OUT_REG_EN: adds one output register (OUT and
// valid_out), making the latency 5 edges.
// -----------------------------------------------------------------------------
module mod_mul
    import kyber_pkg::*;
(
    input  logic     clk,
    input  logic     r,
    mod_mul_if.slave bus
);

    prod_t  c_reg;
    logic   v1;
    coeff_t red_out;
    logic   red_valid;

    // Stage 1: 4095*4095 < 2^24, so the 24-bit product never overflows.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            c_reg <= '0;
            v1    <= 1'b0;
        end else begin
            c_reg <= prod_t'(bus.A) * prod_t'(bus.B);
            v1    <= bus.valid_in;
        end
    end

    mod_mul_barrett_reduce u_reduce (
        .clk       (clk),
        .r         (r),
        .c_in      (c_reg),
        .valid_in  (v1),
        .res       (red_out),
        .valid_out (red_valid)
    );

`ifdef MOD_MUL_OUT_REG_EN
    coeff_t out_q;
    logic   valid_q;

    // Plain delay: red_out already holds between results, so OUT does too.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= red_out;
            valid_q <= red_valid;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.valid_out = valid_q;
`else
    assign bus.OUT       = red_out;
    assign bus.valid_out = red_valid;
`endif

endmodule

// File: tb/tb_mod_mul.sv
// -----------------------------------------------------------------------------
// tb_mod_mul
// Self-checking bench for mod_mul. A cycle monitor compares valid_out/OUT on
// every falling edge against a reference built from (A*B) % 3329 and the
// latency; directed tables and hand-written sequences cover the listed cases.
// -----------------------------------------------------------------------------
module tb_mod_mul;
    import kyber_pkg::*;

`ifdef MOD_MUL_OUT_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic r   = 1'b0;
    always #5 clk = ~clk;

    mod_mul_if bus ();

    mod_mul dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change just after a rising edge and are sampled on the next one.
    task automatic drive(input logic v, input int a, input int b);
        @(posedge clk);
        #1;
        bus.valid_in = v;
        bus.A        = 12'(a);
        bus.B        = 12'(b);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic valid;
        int   val;
    } samp_t;

    samp_t      exp_q[$];   // last LAT sampled inputs with their expected result
    logic [11:0] obs_q[$];  // every valid OUT observed, in order
    int         last_out = 0;

    initial begin : monitor
        samp_t s;
        samp_t old;
        int    ev;
        forever begin
            @(negedge clk);
            if (!r) begin
                exp_q.delete();
                last_out = 0;
                check("reset_valid_out", int'(bus.valid_out), 0);
                check("reset_out", int'(bus.OUT), 0);
            end else begin
                ev = 0;
                if (exp_q.size() >= LAT) begin
                    old = exp_q[exp_q.size() - LAT];
                    ev  = int'(old.valid);
                    if (old.valid) last_out = old.val;
                end
                check("valid_out", int'(bus.valid_out), ev);
                check("out", int'(bus.OUT), last_out);
                if (bus.valid_out) obs_q.push_back(bus.OUT);
                s.valid = bus.valid_in;
                s.val   = (int'(bus.A) * int'(bus.B)) % 3329;
                exp_q.push_back(s);
                if (exp_q.size() > LAT) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t tbl[8];

    initial begin : main
        tbl[0] = '{0,    0,    0};
        tbl[1] = '{1000, 3,    3000};
        tbl[2] = '{1000, 1000, 1300};
        tbl[3] = '{3320, 3320, 81};
        tbl[4] = '{3328, 3328, 1};
        tbl[5] = '{3328, 1,    3328};
        tbl[6] = '{4095, 4095, 852};   // 16769025 = 5037*3329 + 852
        tbl[7] = '{3329, 3329, 0};

        // Reset held with valid traffic on the inputs.
        bus.valid_in = 1'b1;
        bus.A        = 12'($urandom_range(0, 4095));
        bus.B        = 12'($urandom_range(0, 4095));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_valid_out", int'(bus.valid_out), 0);
            check("rst_hold_out", int'(bus.OUT), 0);
            bus.A = 12'($urandom_range(0, 4095));
            bus.B = 12'($urandom_range(0, 4095));
        end
        bus.valid_in = 1'b0;
        r = 1'b1;

        // Directed back-to-back stream.
        drive(1'b0, 0, 0);
        obs_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, tbl[i].a, tbl[i].b);
        drive(1'b0, 0, 0);
        repeat (LAT + 2) @(posedge clk);
        check("tbl_count", obs_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_q.size()) check($sformatf("tbl_%0d", i), int'(obs_q[i]), tbl[i].exp);
            else                  check($sformatf("tbl_%0d", i), -1, tbl[i].exp);
        end

        // Bubble: valid 1,0,1 -> outputs 35, held 35, 0.
        drive(1'b1, 5, 7);
        drive(1'b0, 1234, 999);
        drive(1'b1, 3329, 2);
        drive(1'b0, 0, 0);
        repeat (LAT - 3) @(posedge clk);
        #1;
        check("bubble0_valid", int'(bus.valid_out), 1);
        check("bubble0_out", int'(bus.OUT), 35);
        @(posedge clk);
        #1;
        check("bubble1_valid", int'(bus.valid_out), 0);
        check("bubble1_out_held", int'(bus.OUT), 35);
        @(posedge clk);
        #1;
        check("bubble2_valid", int'(bus.valid_out), 1);
        check("bubble2_out", int'(bus.OUT), 0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom_range(1, 4095), $urandom_range(1, 4095));
        @(posedge clk);
        #1;
        r = 1'b0;
        #1;
        check("midrst_valid_out", int'(bus.valid_out), 0);
        check("midrst_out", int'(bus.OUT), 0);
        bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        r = 1'b1;
        obs_q.delete();
        repeat (LAT + 3) @(posedge clk);
        check("no_stale_valid", obs_q.size(), 0);

        // Random continuous stream, checked cycle by cycle by the monitor.
        obs_q.delete();
        for (int i = 0; i < 10000; i++) drive(1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095));
        drive(1'b0, 0, 0);
        repeat (LAT + 2) @(posedge clk);
        check("rand_count", obs_q.size(), 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
